// File: rtl/rf_pkg.sv
// Shared types and the write-forwarding helper for the multi-port register file.
package rf_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int ADDR_W       = $clog2(NUM_REGS_DEF);

  // fwd_hit works on padded vectors so one function serves any port count up to MAX_WR.
  localparam int MAX_WR     = 8;
  localparam int FWD_IDX_W  = 3;
  localparam int MAX_ADDR_W = 16;

  typedef logic [ADDR_W-1:0]     reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

  typedef struct packed {
    logic                 hit;
    logic [FWD_IDX_W-1:0] idx;
  } fwd_hit_t;

  // Later ports overwrite earlier matches, so the highest-index enabled writer wins.
  function automatic fwd_hit_t fwd_hit(
    input logic [MAX_ADDR_W-1:0]             sel,
    input logic [MAX_WR-1:0]                 wr_en,
    input logic [MAX_WR-1:0][MAX_ADDR_W-1:0] wr_dst
  );
    fwd_hit_t res;
    res = '0;
    for (int i = 0; i < MAX_WR; i++) begin
      if (wr_en[i] && (wr_dst[i] == sel)) begin
        res.hit = 1'b1;
        res.idx = FWD_IDX_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: storage select, write-through bypass, zero-reg forcing, stall flag.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic [ADDR_W-1:0]                 sel_i,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]   regs_i,
  input  logic [NUM_REGS-1:0]               busy_i,
  input  logic [NUM_WR-1:0]                 wr_en_i,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]     wr_dst_i,
  input  logic [NUM_WR-1:0][DATA_W-1:0]     wr_data_i,
  output logic [DATA_W-1:0]                 data_o,
  output logic                              busy_o
);

  logic [MAX_WR-1:0]                 en_pad;
  logic [MAX_WR-1:0][MAX_ADDR_W-1:0] dst_pad;
  fwd_hit_t                          hit;

  always_comb begin
    en_pad  = '0;
    dst_pad = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      en_pad[w]  = wr_en_i[w];
      dst_pad[w] = MAX_ADDR_W'(wr_dst_i[w]);
    end
    hit = fwd_hit(MAX_ADDR_W'(sel_i), en_pad, dst_pad);
  end

  always_comb begin
    data_o = regs_i[sel_i];
    busy_o = busy_i[sel_i] & ~hit.hit;
    if (hit.hit) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (hit.idx == FWD_IDX_W'(w)) data_o = wr_data_i[w];
      end
    end
    if ((ZERO_REG != 0) && (sel_i == '0)) begin
      data_o = '0;
      busy_o = 1'b0;
    end
  end

endmodule

// File: rtl/rf_multiport_sb.sv
// Multi-port integer register file with forwarding and a busy-bit scoreboard for decode.
module rf_multiport_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]    rd_sel_i,
  output logic [NUM_RD-1:0][DATA_W-1:0]    rd_data_o,
  output logic [NUM_RD-1:0]                rd_busy_o,
  input  logic [NUM_WR-1:0]                wr_en_i,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]    wr_dst_i,
  input  logic [NUM_WR-1:0][DATA_W-1:0]    wr_data_i,
  input  logic                             rsv_en_i,
  input  logic [ADDR_W-1:0]                rsv_dst_i,
  output logic [NUM_REGS-1:0]              busy_o
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]             busy_q, busy_d;
  logic [NUM_REGS-1:0]             wr_hit, rsv_vec;
  logic [NUM_WR-1:0]               wr_en_eff;

  // Gating enables with reset keeps the bypass path from leaking write data while in reset.
  assign wr_en_eff = wr_en_i & {NUM_WR{rst_n_i}};

  always_comb begin
    regs_d  = regs_q;
    wr_hit  = '0;
    rsv_vec = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en_eff[w]) begin
        wr_hit[wr_dst_i[w]] = 1'b1;
        if (!((ZERO_REG != 0) && (wr_dst_i[w] == '0))) regs_d[wr_dst_i[w]] = wr_data_i[w];
      end
    end
    rsv_vec[rsv_dst_i] = rsv_en_i;
    // A reserve outranks a same-cycle writeback: the newer producer still owes a result.
    busy_d = (busy_q & ~wr_hit) | rsv_vec;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    rf_read_port #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG),
      .ADDR_W   (ADDR_W)
    ) u_rd (
      .sel_i     (rd_sel_i[gi]),
      .regs_i    (regs_q),
      .busy_i    (busy_q),
      .wr_en_i   (wr_en_eff),
      .wr_dst_i  (wr_dst_i),
      .wr_data_i (wr_data_i),
      .data_o    (rd_data_o[gi]),
      .busy_o    (rd_busy_o[gi])
    );
  end

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Directed bench for rf_multiport_sb; a ZERO_REG=0 twin shares the stimulus.
module tb_rf_multiport_sb;

  logic                 clk_i = 1'b0;
  logic                 rst_n_i;
  logic [1:0][4:0]      rd_sel_i;
  logic [1:0][31:0]     rd_data_o, rd_data_nz;
  logic [1:0]           rd_busy_o, rd_busy_nz;
  logic [1:0]           wr_en_i;
  logic [1:0][4:0]      wr_dst_i;
  logic [1:0][31:0]     wr_data_i;
  logic                 rsv_en_i;
  logic [4:0]           rsv_dst_i;
  logic [31:0]          busy_o, busy_nz;

  int passed = 0;
  int total  = 0;

  always #5 clk_i = ~clk_i;

  rf_multiport_sb #(.ZERO_REG(1)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .rd_sel_i(rd_sel_i), .rd_data_o(rd_data_o),
    .rd_busy_o(rd_busy_o), .wr_en_i(wr_en_i), .wr_dst_i(wr_dst_i), .wr_data_i(wr_data_i),
    .rsv_en_i(rsv_en_i), .rsv_dst_i(rsv_dst_i), .busy_o(busy_o)
  );

  rf_multiport_sb #(.ZERO_REG(0)) dut_nz (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .rd_sel_i(rd_sel_i), .rd_data_o(rd_data_nz),
    .rd_busy_o(rd_busy_nz), .wr_en_i(wr_en_i), .wr_dst_i(wr_dst_i), .wr_data_i(wr_data_i),
    .rsv_en_i(rsv_en_i), .rsv_dst_i(rsv_dst_i), .busy_o(busy_nz)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    $display("check %-18s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    wr_en_i  = '0;
    rsv_en_i = 1'b0;
  endtask

  initial begin
    rst_n_i   = 1'b0;
    rd_sel_i  = '0;
    wr_en_i   = '0;
    wr_dst_i  = '0;
    wr_data_i = '0;
    rsv_en_i  = 1'b0;
    rsv_dst_i = '0;
    tick();
    #1;
    check("rst_rd0", rd_data_o[0], 32'h0);
    check("rst_busy", busy_o, 32'h0);
    rst_n_i = 1'b1;
    tick();

    // Reset wipes a stored value immediately, and suppresses bypass/reserve while held
    wr_en_i = 2'b01; wr_dst_i[0] = 5'd5; wr_data_i[0] = 32'hDEADBEEF;
    tick();
    idle();
    rd_sel_i[0] = 5'd5;
    #1;
    check("pre_rst_r5", rd_data_o[0], 32'hDEADBEEF);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("async_rst_r5", rd_data_o[0], 32'h0);
    check("async_rst_busy", busy_o, 32'h0);
    wr_en_i = 2'b01; wr_data_i[0] = 32'h0BAD0BAD;
    rsv_en_i = 1'b1; rsv_dst_i = 5'd5;
    #1;
    check("rst_no_bypass", rd_data_o[0], 32'h0);
    tick();
    check("rst_no_rsv", busy_o, 32'h0);
    idle();
    rst_n_i = 1'b1;
    #1;
    check("rst_r5_clear", rd_data_o[0], 32'h0);

    // Same-cycle bypass then stored value
    wr_en_i = 2'b01; wr_dst_i[0] = 5'd3; wr_data_i[0] = 32'h12345678;
    rd_sel_i[0] = 5'd3;
    #1;
    check("bypass_r3", rd_data_o[0], 32'h12345678);
    tick();
    idle();
    #1;
    check("stored_r3", rd_data_o[0], 32'h12345678);

    // Collision: port 1 wins
    wr_en_i = 2'b11;
    wr_dst_i[0] = 5'd7; wr_data_i[0] = 32'h1111;
    wr_dst_i[1] = 5'd7; wr_data_i[1] = 32'h2222;
    rd_sel_i[0] = 5'd7;
    #1;
    check("coll_bypass", rd_data_o[0], 32'h2222);
    tick();
    idle();
    #1;
    check("coll_stored", rd_data_o[0], 32'h2222);

    // Zero register vs. ordinary r0
    wr_en_i = 2'b01; wr_dst_i[0] = 5'd0; wr_data_i[0] = 32'hFFFFFFFF;
    rd_sel_i[0] = 5'd0;
    #1;
    check("zero_bypass", rd_data_o[0], 32'h0);
    check("nz_bypass", rd_data_nz[0], 32'hFFFFFFFF);
    tick();
    idle();
    rsv_en_i = 1'b1; rsv_dst_i = 5'd0;
    #1;
    check("zero_stored", rd_data_o[0], 32'h0);
    check("nz_stored", rd_data_nz[0], 32'hFFFFFFFF);
    tick();
    idle();
    #1;
    check("zero_busy0", {31'h0, busy_o[0]}, 32'h0);
    check("nz_busy0", {31'h0, busy_nz[0]}, 32'h1);
    check("zero_rd_busy0", {31'h0, rd_busy_o[0]}, 32'h0);

    // Scoreboard lifecycle on r9
    rsv_en_i = 1'b1; rsv_dst_i = 5'd9;
    rd_sel_i[1] = 5'd9;
    #1;
    check("sb_pre_busy", {31'h0, rd_busy_o[1]}, 32'h0);
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      #1;
      check("sb_rd_busy", {31'h0, rd_busy_o[1]}, 32'h1);
      check("sb_busy9", {31'h0, busy_o[9]}, 32'h1);
      tick();
    end
    wr_en_i = 2'b10; wr_dst_i[1] = 5'd9; wr_data_i[1] = 32'hABCD;
    #1;
    check("sb_wb_rd_busy", {31'h0, rd_busy_o[1]}, 32'h0);
    check("sb_wb_data", rd_data_o[1], 32'hABCD);
    check("sb_wb_busy9_reg", {31'h0, busy_o[9]}, 32'h1);
    tick();
    idle();
    #1;
    check("sb_cleared9", {31'h0, busy_o[9]}, 32'h0);
    check("sb_stored9", rd_data_o[1], 32'hABCD);

    // Reserve and write to r4 in one cycle
    rsv_en_i = 1'b1; rsv_dst_i = 5'd4;
    wr_en_i = 2'b01; wr_dst_i[0] = 5'd4; wr_data_i[0] = 32'h55;
    rd_sel_i[0] = 5'd4;
    #1;
    check("race_rd_busy", {31'h0, rd_busy_o[0]}, 32'h0);
    tick();
    idle();
    #1;
    check("race_busy4", {31'h0, busy_o[4]}, 32'h1);
    check("race_stored4", rd_data_o[0], 32'h55);
    check("race_rd_busy_after", {31'h0, rd_busy_o[0]}, 32'h1);
    check("race_busy_vec", busy_o, 32'h0000_0010);

    // Write to a non-busy register leaves busy at 0
    wr_en_i = 2'b10; wr_dst_i[1] = 5'd12; wr_data_i[1] = 32'h77;
    tick();
    idle();
    #1;
    check("nonbusy_write", {31'h0, busy_o[12]}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
